uart_host_loader: RTL

- Host-side initiator for the UART program/dump link, driven by an on-chip or FPGA-side controller.
- Serializes an IMEM image of IMEM_BYTES bytes from a byte stream onto tx_out, then deserializes DMEM_BYTES bytes arriving on rx_in and presents them as an output stream.
- Used for self-test and for FPGA bring-up of the UART-controlled CPU subsystem.

---
 rtl/uart_host_pkg.sv | 27 ++
 rtl/uart_host_rx.sv | 134 +++++++++++++
 rtl/uart_host_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_pkg.sv
// Shared types and constants for the UART host loader.
package uart_host_pkg;

    // Top-level run sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV,
        ST_DONE,
        ST_ERROR
    } host_state_t;

    // Receiver frame states
    typedef enum logic [1:0] {
        RX_HUNT,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Start + 8 data + stop
    localparam int FRAME_BITS = 10;

    // Smallest bit period the receiver can still mid-bit sample
    localparam int MIN_CPB = 4;

endpackage

// File: rtl/uart_host_rx.sv
// UART 8N1 receiver: 2-FF synchronizer, falling-edge start detect,
// half-period start re-check, mid-bit data sampling and stop-bit framing check.
module uart_host_rx
    import uart_host_pkg::*;
#(
    parameter int COUNTER_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [COUNTER_WIDTH-1:0] cpb,
    input  logic                     rx_in,
    output logic                     byte_valid,
    output logic [7:0]               byte_data,
    output logic                     frame_err,
    output logic                     hunting
);

    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    logic                     sync1_q, sync2_q, prev_q;
    rx_state_t                state_q, state_d;
    logic [COUNTER_WIDTH-1:0] tmr_q, tmr_d;
    logic [2:0]               bit_q, bit_d;
    logic [7:0]               shift_q, shift_d;
    logic                     valid_q, valid_d;
    logic [7:0]               data_q, data_d;
    logic                     err_q, err_d;
    logic [COUNTER_WIDTH-1:0] half_w, last_w;
    logic                     fall_w;

    assign half_w = cpb >> 1;
    assign last_w = cpb - ONE;
    // prev_q is only an edge-history tap behind the two metastability stages
    assign fall_w = prev_q & ~sync2_q;

    assign byte_valid = valid_q;
    assign byte_data  = data_q;
    assign frame_err  = err_q;
    assign hunting    = en && ((state_q == RX_HUNT) || (state_q == RX_START));

    // Synchronize the asynchronous line; idles high so reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Frame sequencing; forced back to hunting whenever disabled
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        data_d  = data_q;
        err_d   = 1'b0;
        if (!en) begin
            state_d = RX_HUNT;
            tmr_d   = '0;
        end else begin
            case (state_q)
                RX_HUNT: begin
                    tmr_d = '0;
                    if (fall_w) begin
                        state_d = RX_START;
                    end
                end
                RX_START: begin
                    if (tmr_q == half_w) begin
                        tmr_d = '0;
                        if (sync2_q) begin
                            state_d = RX_HUNT;  // glitch, not a real start bit
                        end else begin
                            state_d = RX_DATA;
                            bit_d   = 3'd0;
                        end
                    end
                end
                RX_DATA: begin
                    if (tmr_q == last_w) begin
                        tmr_d   = '0;
                        shift_d = {sync2_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tmr_q == last_w) begin
                        tmr_d   = '0;
                        state_d = RX_HUNT;
                        if (sync2_q) begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = RX_HUNT;
            endcase
        end
    end

    // Receiver state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_HUNT;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/uart_host_loader.sv
// UART host loader: sends an IMEM image as 8N1 frames on tx_out, then collects
// DMEM_BYTES dump bytes from rx_in. Optional feature macro UART_HOST_CSUM_EN adds
// an 8-bit running sum of the dump bytes on output csum.
module uart_host_loader
    import uart_host_pkg::*;
#(
    parameter int COUNTER_WIDTH = 24,
    parameter int IMEM_BYTES    = 64,
    parameter int DMEM_BYTES    = 64,
    parameter int TIMEOUT_BITS  = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COUNTER_WIDTH-1:0] cycles_per_bit,
    input  logic                     start,
    input  logic                     img_valid,
    input  logic [7:0]               img_data,
    output logic                     img_ready,
    output logic                     tx_out,
    input  logic                     rx_in,
    output logic                     dump_valid,
    output logic [7:0]               dump_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error
`ifdef UART_HOST_CSUM_EN
    ,
    output logic [7:0]               csum
`endif
);

    localparam int SENT_W = $clog2(IMEM_BYTES + 1);
    localparam int RECV_W = $clog2(DMEM_BYTES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_BITS + 1);

    localparam logic [COUNTER_WIDTH-1:0] ONE         = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] CPB_MIN     = COUNTER_WIDTH'(MIN_CPB);
    localparam logic [SENT_W-1:0]        SENT_MAX    = SENT_W'(IMEM_BYTES);
    localparam logic [RECV_W-1:0]        RECV_LAST   = RECV_W'(DMEM_BYTES - 1);
    localparam logic [TO_W-1:0]          TO_LAST     = TO_W'(TIMEOUT_BITS - 1);
    localparam logic [3:0]               TX_LAST_BIT = 4'(FRAME_BITS - 1);

    host_state_t              state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cpb_q, cpb_d;
    logic [SENT_W-1:0]        sent_q, sent_d;
    logic [RECV_W-1:0]        recv_q, recv_d;
    logic [COUNTER_WIDTH-1:0] to_cyc_q, to_cyc_d;
    logic [TO_W-1:0]          to_bits_q, to_bits_d;
    logic                     tx_q, tx_d;
    logic                     tx_active_q, tx_active_d;
    logic [3:0]               tx_bit_q, tx_bit_d;
    logic [COUNTER_WIDTH-1:0] tx_tmr_q, tx_tmr_d;
    logic [8:0]               tx_shift_q, tx_shift_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
`ifdef UART_HOST_CSUM_EN
    logic [7:0]               csum_q, csum_d;
`endif

    logic [COUNTER_WIDTH-1:0] cpb_last;
    logic                     tx_last;
    logic                     rx_en, rx_valid, rx_err, rx_hunting;
    logic [7:0]               rx_data;

    assign cpb_last = cpb_q - ONE;
    // Final cycle of a stop bit counts as free so the next start bit follows with no gap
    assign tx_last  = tx_active_q && (tx_bit_q == TX_LAST_BIT) && (tx_tmr_q == cpb_last);
    assign img_ready = (state_q == ST_SEND) && (!tx_active_q || tx_last) && (sent_q < SENT_MAX);
    assign rx_en    = (state_q == ST_RECV);

    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign dump_valid = rx_valid;
    assign dump_data  = rx_data;
`ifdef UART_HOST_CSUM_EN
    assign csum       = csum_q;
`endif

    uart_host_rx #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (rx_en),
        .cpb       (cpb_q),
        .rx_in     (rx_in),
        .byte_valid(rx_valid),
        .byte_data (rx_data),
        .frame_err (rx_err),
        .hunting   (rx_hunting)
    );

    // Next-state logic for the run sequencer, TX serializer and timers
    always_comb begin
        state_d     = state_q;
        cpb_d       = cpb_q;
        sent_d      = sent_q;
        recv_d      = recv_q;
        to_cyc_d    = to_cyc_q;
        to_bits_d   = to_bits_q;
        tx_d        = tx_q;
        tx_active_d = tx_active_q;
        tx_bit_d    = tx_bit_q;
        tx_tmr_d    = tx_tmr_q;
        tx_shift_d  = tx_shift_q;
        error_d     = error_q;
`ifdef UART_HOST_CSUM_EN
        csum_d      = csum_q;
`endif

        // Serializer: hold each bit cpb cycles, shift the next one out at the boundary
        if (tx_active_q) begin
            if (tx_tmr_q == cpb_last) begin
                tx_tmr_d = '0;
                if (tx_bit_q == TX_LAST_BIT) begin
                    tx_active_d = 1'b0;
                end else begin
                    tx_bit_d   = tx_bit_q + 4'd1;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                end
            end else begin
                tx_tmr_d = tx_tmr_q + ONE;
            end
        end

        // Image handshake: start bit goes out next cycle, data then stop queued behind it
        if (img_ready && img_valid) begin
            tx_active_d = 1'b1;
            tx_bit_d    = 4'd0;
            tx_tmr_d    = '0;
            tx_d        = 1'b0;
            tx_shift_d  = {1'b1, img_data};
            sent_d      = sent_q + SENT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cycles_per_bit < CPB_MIN) begin
                        error_d = 1'b1;
                    end else begin
                        state_d     = ST_SEND;
                        cpb_d       = cycles_per_bit;
                        error_d     = 1'b0;
                        sent_d      = '0;
                        recv_d      = '0;
                        to_cyc_d    = '0;
                        to_bits_d   = '0;
                        tx_active_d = 1'b0;
                        tx_d        = 1'b1;
`ifdef UART_HOST_CSUM_EN
                        csum_d      = '0;
`endif
                    end
                end
            end
            ST_SEND: begin
                if (tx_last && (sent_q == SENT_MAX)) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                // Inter-byte timer only runs while no frame is being assembled
                if (rx_hunting) begin
                    if (to_cyc_q == cpb_last) begin
                        to_cyc_d  = '0;
                        to_bits_d = to_bits_q + TO_W'(1);
                    end else begin
                        to_cyc_d = to_cyc_q + ONE;
                    end
                end else begin
                    to_cyc_d  = '0;
                    to_bits_d = '0;
                end
                if (rx_err) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end else if (rx_valid) begin
                    recv_d = recv_q + RECV_W'(1);
`ifdef UART_HOST_CSUM_EN
                    csum_d = csum_q + rx_data;
`endif
                    if (recv_q == RECV_LAST) begin
                        state_d = ST_DONE;
                    end
                end else if (rx_hunting && (to_cyc_q == cpb_last) && (to_bits_q == TO_LAST)) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Sequencer, serializer and registered outputs; reset drives tx_out high at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cpb_q       <= '0;
            sent_q      <= '0;
            recv_q      <= '0;
            to_cyc_q    <= '0;
            to_bits_q   <= '0;
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            tx_bit_q    <= '0;
            tx_tmr_q    <= '0;
            tx_shift_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef UART_HOST_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cpb_q       <= cpb_d;
            sent_q      <= sent_d;
            recv_q      <= recv_d;
            to_cyc_q    <= to_cyc_d;
            to_bits_q   <= to_bits_d;
            tx_q        <= tx_d;
            tx_active_q <= tx_active_d;
            tx_bit_q    <= tx_bit_d;
            tx_tmr_q    <= tx_tmr_d;
            tx_shift_q  <= tx_shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef UART_HOST_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule
